// File: rtl/aes_byte_loader.sv
// Upstream feeder for the byte-serial AES-128 core: accepts a key/plaintext pair,
// pulses the core reset, streams 16 bytes of each operand, then waits for completion.
module aes_byte_loader #(
    parameter int RST_CYCLES = 1,
    parameter int TIMEOUT    = 200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key_in,
    input  logic [127:0] data_in,
    output logic         core_rst,
    output logic [7:0]   keyin,
    output logic [7:0]   datain,
    input  logic         core_valid,
    output logic         busy,
    output logic         done,
    output logic         err
);

    // One counter serves RST, LOAD and WAIT, so it must hold the largest terminal value.
    localparam int CW_T = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    localparam int CW   = ($clog2(RST_CYCLES + 1) > CW_T) ? $clog2(RST_CYCLES + 1) : CW_T;

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_LAST = CW'(15);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RST,
        S_LOAD,
        S_WAIT
    } state_e;

    state_e         state_q;
    logic [127:0]   key_q;
    logic [127:0]   data_q;
    logic [CW-1:0]  cnt_q;
    logic           in_ready_q;
    logic           done_q;
    logic           err_q;

    // NOTE: every register below is updated with <= so all branches see the
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            key_q      <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        key_q      <= key_in;
                        data_q     <= data_in;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RST;
                    end
                end
                S_RST: begin
                    if (cnt_q == RST_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_LOAD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    key_q  <= {key_q[119:0], 8'h00};
                    data_q <= {data_q[119:0], 8'h00};
                    if (cnt_q == LOAD_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    // Completion is checked first so a coincident timeout never raises err.
                    if (core_valid) begin
                        done_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else if (cnt_q == WAIT_LAST) begin
                        err_q      <= 1'b1;
                        in_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Byte lanes are gated by state so they read zero outside LOAD, including during reset.
    assign keyin    = (state_q == S_LOAD) ? key_q[127:120]  : 8'h00;
    assign datain   = (state_q == S_LOAD) ? data_q[127:120] : 8'h00;
    assign core_rst = (state_q == S_IDLE) || (state_q == S_RST);
    assign busy     = (state_q != S_IDLE);
    assign in_ready = in_ready_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_aes_byte_loader.sv
// Self-checking bench for aes_byte_loader: the bench plays the AES core, drives
// completion latencies and compares every cycle against an expected-timeline model.
module tb_aes_byte_loader;

    localparam int R  = 1;
    localparam int TO = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key_in;
    logic [127:0] data_in;
    logic         core_rst;
    logic [7:0]   keyin;
    logic [7:0]   datain;
    logic         core_valid;
    logic         busy;
    logic         done;
    logic         err;

    int tests = 0;
    int fails = 0;

    aes_byte_loader #(.RST_CYCLES(R), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .key_in     (key_in),
        .data_in    (data_in),
        .core_rst   (core_rst),
        .keyin      (keyin),
        .datain     (datain),
        .core_valid (core_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Observed vector: {in_ready, core_rst, busy, done, err, keyin, datain}
    function automatic logic [20:0] obs_vec();
        return {in_ready, core_rst, busy, done, err, keyin, datain};
    endfunction

    localparam logic [20:0] IDLE_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};

    // Runs one block from acceptance to done/err. lat is the WAIT-cycle index at which
    // the core raises its flag (lat > TO means never). hold keeps in_valid high with
    // changing operands throughout, to show no re-capture happens while busy.
    task automatic run_block(input string name, input logic [127:0] k, input logic [127:0] d,
                             input int lat, input bit hold);
        int n;
        int end_w;
        int last;
        int b;
        int w;
        logic [20:0] exp_v;
        logic [20:0] got;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_wait: in_ready got %b expected 1", name, in_ready);
            return;
        end
        in_valid = 1'b1;
        key_in   = k;
        data_in  = d;
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        end_w = (lat < TO) ? lat : TO;
        last  = R + 16 + end_w + 1;
        for (int c = 0; c <= last; c++) begin
            if (hold) begin
                key_in  = {$urandom, $urandom, $urandom, $urandom};
                data_in = {$urandom, $urandom, $urandom, $urandom};
            end
            if (c < R) begin
                exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
            end else if (c < R + 16) begin
                b = c - R;
                exp_v = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, k[127 - 8*b -: 8], d[127 - 8*b -: 8]};
            end else if (c < last) begin
                exp_v = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
            end else begin
                exp_v = {1'b1, 1'b1, 1'b0, (lat <= TO), (lat > TO), 8'h00, 8'h00};
            end
            got = obs_vec();
            tests++;
            if (got !== exp_v) begin
                fails++;
                $display("FAIL %s cycle %0d: {rdy,crst,busy,done,err,key,dat} got %h expected %h",
                         name, c, got, exp_v);
            end
            if (c < last) begin
                if (c >= R + 16) begin
                    w = c - R - 16;
                    core_valid = (w >= lat);
                end
                @(negedge clk);
            end else begin
                core_valid = 1'b0;
            end
        end
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        tests++;
        if (obs_vec() !== IDLE_VEC) begin
            fails++;
            $display("FAIL %s idle: got %h expected %h", name, obs_vec(), IDLE_VEC);
        end
    endtask

    task automatic test_reset();
        logic [20:0] exp_v;
        rst = 1'b1;
        in_valid = 1'b0;
        key_in = '0;
        data_in = '0;
        core_valid = 1'b0;
        repeat (2) @(negedge clk);
        exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tests++;
        if (obs_vec() !== exp_v) begin
            fails++;
            $display("FAIL reset_hold: got %h expected %h", obs_vec(), exp_v);
        end
        rst = 1'b0;
        idle_check("reset_release");
    endtask

    task automatic test_fips();
        run_block("fips", 128'h000102030405060708090a0b0c0d0e0f,
                  128'h00112233445566778899aabbccddeeff, 3, 1'b0);
        idle_check("fips_done_once");
    endtask

    task automatic test_byte_order();
        run_block("byte_order", 128'hff000000000000000000000000000001, 128'h0, 1, 1'b0);
        idle_check("byte_order_after");
    endtask

    task automatic test_timeout();
        run_block("timeout", {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, 99, 1'b0);
        idle_check("timeout_err_once");
        run_block("coincide", {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, TO, 1'b0);
        idle_check("coincide_after");
    endtask

    task automatic test_stale_flag();
        core_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (done !== 1'b0 || err !== 1'b0) begin
                fails++;
                $display("FAIL stale_idle: done/err got %b%b expected 00", done, err);
            end
        end
        run_block("stale", {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0);
        idle_check("stale_after");
    endtask

    task automatic test_mid_load_reset();
        logic [127:0] k;
        logic [127:0] d;
        logic [20:0]  exp_v;
        k = {$urandom, $urandom, $urandom, $urandom};
        d = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        key_in = k;
        data_in = d;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (R + 7) @(negedge clk);
        exp_v = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, k[127-56 -: 8], d[127-56 -: 8]};
        tests++;
        if (obs_vec() !== exp_v) begin
            fails++;
            $display("FAIL midrst_byte7: got %h expected %h", obs_vec(), exp_v);
        end
        #1 rst = 1'b1;
        #1;
        exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tests++;
        if (obs_vec() !== exp_v) begin
            fails++;
            $display("FAIL midrst_async: got %h expected %h", obs_vec(), exp_v);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL midrst_ready_low: in_ready got %b expected 0", in_ready);
        end
        idle_check("midrst_ready_high");
        idle_check("midrst_no_pulse");
    endtask

    task automatic test_back_to_back();
        logic [127:0] k2;
        logic [127:0] d2;
        k2 = {$urandom, $urandom, $urandom, $urandom};
        d2 = {$urandom, $urandom, $urandom, $urandom};
        run_block("busy_hold", {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom}, 2, 1'b1);
        run_block("back_to_back", k2, d2, 1, 1'b0);
        idle_check("back_to_back_after");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_block("random", {$urandom, $urandom, $urandom, $urandom},
                      {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, TO + 1), 1'b0);
            idle_check("random_after");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fips();
        test_byte_order();
        test_timeout();
        test_stale_flag();
        test_mid_load_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_byte_loader.md
Name: aes_byte_loader

Overview:
- Upstream feeder for the byte-serial AES-128 encryption core.
- Accepts one 128-bit key and one 128-bit plaintext block through a valid/ready handshake.
- Pulses the core's reset, then streams both operands into the core one byte per clock during the core's 16-cycle load window.
- Watches the core's sticky completion flag and reports completion or timeout upstream.

Parameters:
- RST_CYCLES, 1, number of cycles core_rst is held high after a block is accepted (minimum 1).
- TIMEOUT, 200, maximum cycles to wait in WAIT for core_valid before flagging an error.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  key_in/data_in hold a block to encrypt.
- in_ready  output  1  loader can accept a block; high only in IDLE.
- key_in  input  128  AES-128 key; byte 0 is [127:120].
- data_in  input  128  plaintext; byte 0 is [127:120].
- core_rst  output  1  reset to the core (synchronous on the core side).
- keyin  output  8  key byte stream to the core.
- datain  output  8  plaintext byte stream to the core.
- core_valid  input  1  core completion flag; sticky until core reset.
- busy  output  1  high in RST, LOAD and WAIT.
- done  output  1  one-cycle pulse when core_valid is seen in WAIT.
- err  output  1  one-cycle pulse on WAIT timeout.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - Shift registers and counters clear.
  - keyin=datain=0, core_rst=1, in_ready=0 while rst is high, busy=0, done=0, err=0.
- IDLE:
  - in_ready=1, core_rst=1, keyin=datain=0.
  - When in_valid&in_ready: capture key_in and data_in into two 128-bit shift registers, clear the counter, go to RST.
- RST:
  - core_rst=1, in_ready=0.
  - Stays RST_CYCLES cycles, then goes to LOAD.
- LOAD:
  - core_rst=0.
  - keyin = key shift register [127:120] and datain = data shift register [127:120], combinational from the registers.
  - Each cycle both registers shift left by 8 bits, zero-filled.
  - Exactly 16 cycles. Byte k (k=0..15) appears on the k-th cycle after core_rst falls, which is core load-state count k.
  - After the 16th byte, go to WAIT.
- WAIT:
  - core_rst=0, keyin=datain=0.
  - The timeout counter increments each cycle.
  - If core_valid=1: done=1 for one cycle, go to IDLE.
  - Else, if the counter reaches TIMEOUT: err=1 for one cycle, go to IDLE.
  - If core_valid and the timeout coincide on the same cycle, done wins and err stays 0.
- Pulse and flag timing:
  - done and err are registered and asserted in the cycle the state returns to IDLE.
  - Because IDLE drives core_rst=1, the core's sticky valid clears one cycle after done.
- Counter width:
  - Shared counter width is max(4, $clog2(TIMEOUT+1), $clog2(RST_CYCLES+1)).
  - The counter never wraps inside a state.
- Handshake:
  - in_ready is low outside IDLE; in_valid there is ignored and no capture occurs.
  - in_ready is a registered state decode with no combinational path from in_valid.
- core_valid outside WAIT is ignored, including stale high values from a previous run seen in IDLE/RST.
- Reset mid-operation (any state):
  - Immediate return to IDLE with the reset values above; the captured block is discarded.
  - No done/err pulse.
- Latency, acceptance edge to done: RST_CYCLES + 16 + (core latency after load) + 1 cycles.
- Throughput: one block per run; back-to-back acceptance is possible the cycle after done.

Test Plan:
- FIPS-197 vector: key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff, in_valid=1 one cycle.
  - in_ready falls.
  - core_rst high for 1 cycle, then keyin sequence 00,01,...,0f and datain 00,11,...,ff on 16 consecutive cycles.
  - Then 00/00 until core_valid.
  - done pulses once; in_ready=1 again.
- Byte ordering: key=ff000000..0001, pt=0 -> keyin first=ff, then fourteen 00, last=01; datain=00 for all 16 cycles.
- Timeout: TIMEOUT=5, core_valid tied 0 -> err high for exactly 1 cycle on the 6th WAIT cycle boundary, done=0, state IDLE, core_rst=1.
- Stale flag: core_valid=1 held through IDLE/RST/LOAD -> no done before WAIT; done asserted on the first WAIT cycle.
- Mid-load reset: assert rst asynchronously at LOAD byte 7 -> keyin/datain=0 and core_rst=1 immediately; in_ready=1 one cycle after rst falls; no done/err pulse.
- Busy handshake: in_valid held high with a changing key through LOAD -> no re-capture; the second block is accepted only in the cycle after done, with its byte 0 appearing after RST_CYCLES.
